// File: rtl/ast_packet_arbiter.sv
// Packet-atomic round-robin merge of N_SRC Avalon-ST sources onto one registered sink; 2-cycle first-beat latency.
// A stalled output holds every src_* field stable; one IDLE bubble separates packets.
module ast_packet_arbiter #(
  parameter int N_SRC     = 4,
  parameter int DATA_W    = 64,
  parameter int EMPTY_W   = 3,
  parameter int CHANNEL_W = 4
) (
  input  logic                          clk,
  input  logic                          arst_n,
  input  logic [N_SRC*DATA_W-1:0]       snk_data,
  input  logic [N_SRC-1:0]              snk_sop,
  input  logic [N_SRC-1:0]              snk_eop,
  input  logic [N_SRC-1:0]              snk_valid,
  input  logic [N_SRC*EMPTY_W-1:0]      snk_empty,
  input  logic [N_SRC*CHANNEL_W-1:0]    snk_channel,
  output logic [N_SRC-1:0]              snk_ready,
  output logic [DATA_W-1:0]             src_data,
  output logic                          src_sop,
  output logic                          src_eop,
  output logic                          src_valid,
  output logic [EMPTY_W-1:0]            src_empty,
  output logic [CHANNEL_W-1:0]          src_channel,
  input  logic                          src_ready,
  output logic [$clog2(N_SRC)-1:0]      grant_idx,
  output logic                          busy
);

  localparam int GW = $clog2(N_SRC);

  typedef enum logic {S_IDLE, S_XFER} state_t;

  state_t              r_state;
  logic [GW-1:0]       r_last;

  logic                w_any;
  logic [GW-1:0]       w_pick;
  logic                w_rdy_g;
  logic                w_vld_g;
  logic                w_acc;
  logic [DATA_W-1:0]   w_dat;
  logic                w_sop;
  logic                w_eop;
  logic [EMPTY_W-1:0]  w_emp;
  logic [CHANNEL_W-1:0] w_ch;

  function automatic int wrap_idx(input int a);
    return (a >= N_SRC) ? a - N_SRC : a;
  endfunction

  // Scan downward so the requester closest after r_last is the final (winning) assignment.
  always_comb begin
    w_any  = 1'b0;
    w_pick = '0;
    for (int k = N_SRC; k >= 1; k--) begin
      if (snk_valid[wrap_idx(int'(r_last) + k)]) begin
        w_any  = 1'b1;
        w_pick = GW'(wrap_idx(int'(r_last) + k));
      end
    end
  end

  always_comb begin
    w_dat   = snk_data[int'(grant_idx)*DATA_W +: DATA_W];
    w_emp   = snk_empty[int'(grant_idx)*EMPTY_W +: EMPTY_W];
    w_ch    = snk_channel[int'(grant_idx)*CHANNEL_W +: CHANNEL_W];
    w_sop   = snk_sop[grant_idx];
    w_eop   = snk_eop[grant_idx];
    w_vld_g = snk_valid[grant_idx];
    w_rdy_g = src_ready | ~src_valid;
    w_acc   = (r_state == S_XFER) & w_vld_g & w_rdy_g;
  end

  always_comb begin
    snk_ready = '0;
    if (r_state == S_XFER) snk_ready[grant_idx] = w_rdy_g;
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_state     <= S_IDLE;
      r_last      <= GW'(N_SRC - 1);
      grant_idx   <= '0;
      busy        <= 1'b0;
      src_data    <= '0;
      src_sop     <= 1'b0;
      src_eop     <= 1'b0;
      src_valid   <= 1'b0;
      src_empty   <= '0;
      src_channel <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            grant_idx <= w_pick;
            busy      <= 1'b1;
            r_state   <= S_XFER;
          end
        end
        S_XFER: begin
          // Only eop ends a grant; a valid drop mid-packet just waits.
          if (w_acc && w_eop) begin
            r_last  <= grant_idx;
            busy    <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase

      if (w_rdy_g) begin
        if (w_acc) begin
          src_data    <= w_dat;
          src_sop     <= w_sop;
          src_eop     <= w_eop;
          src_empty   <= w_emp;
          src_channel <= w_ch;
          src_valid   <= 1'b1;
        end else begin
          src_valid   <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_ast_packet_arbiter.sv
// Directed bench for ast_packet_arbiter: per-source beat queues feed the sinks, a scoreboard of
// expected output beats (order, latency, spacing, grant) is popped as src_* handshakes occur.
module tb_ast_packet_arbiter;

  localparam int N  = 4;
  localparam int DW = 64;
  localparam int EW = 3;
  localparam int CW = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              arst_n;
  logic [N*DW-1:0]   snk_data;
  logic [N-1:0]      snk_sop, snk_eop, snk_valid, snk_ready;
  logic [N*EW-1:0]   snk_empty;
  logic [N*CW-1:0]   snk_channel;
  logic [DW-1:0]     src_data;
  logic              src_sop, src_eop, src_valid, src_ready;
  logic [EW-1:0]     src_empty;
  logic [CW-1:0]     src_channel;
  logic [1:0]        grant_idx;
  logic              busy;

  ast_packet_arbiter #(.N_SRC(N), .DATA_W(DW), .EMPTY_W(EW), .CHANNEL_W(CW)) dut (
    .clk(clk), .arst_n(arst_n),
    .snk_data(snk_data), .snk_sop(snk_sop), .snk_eop(snk_eop), .snk_valid(snk_valid),
    .snk_empty(snk_empty), .snk_channel(snk_channel), .snk_ready(snk_ready),
    .src_data(src_data), .src_sop(src_sop), .src_eop(src_eop), .src_valid(src_valid),
    .src_empty(src_empty), .src_channel(src_channel), .src_ready(src_ready),
    .grant_idx(grant_idx), .busy(busy)
  );

  typedef struct {
    logic [63:0] d; logic sop; logic eop; logic [2:0] emp; logic [3:0] ch; int gap;
  } beat_t;

  typedef struct {
    logic [63:0] d; logic sop; logic eop; logic [2:0] emp; logic [3:0] ch;
    int src; int at; int dcyc;
  } exp_t;

  beat_t txq [N][$];
  exp_t  sbq [$];
  int    n_checks = 0;
  int    n_pass   = 0;
  int    cyc      = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expv);
    n_checks = n_checks + 1;
    assert (obs === expv) n_pass = n_pass + 1;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, expv);
  endtask

  // Queue nb beats on source s; the first nexp of them are expected at the output.
  task automatic send(input int s, input int nb, input int nexp, input logic [63:0] base,
                      input logic [3:0] ch, input logic [2:0] emp, input int gap_at,
                      input int gap_n, input bit lat, input int dfirst, input int dn);
    for (int k = 0; k < nb; k++) begin
      beat_t b;
      exp_t  e;
      b.d   = base + 64'(k);
      b.sop = (k == 0);
      b.eop = (k == nb - 1);
      b.emp = b.eop ? emp : 3'd0;
      b.ch  = ch;
      b.gap = (k == gap_at) ? gap_n : 0;
      txq[s].push_back(b);
      if (k < nexp) begin
        e.d = b.d; e.sop = b.sop; e.eop = b.eop; e.emp = b.emp; e.ch = b.ch;
        e.src  = s;
        e.at   = (k == 0 && lat) ? cyc + 3 : -1;
        e.dcyc = (k == 0) ? dfirst : ((k == gap_at) ? gap_n + 1 : dn);
        sbq.push_back(e);
      end
    end
  endtask

  // Source drivers: present queue heads, pop on handshake, honour per-beat valid gaps.
  initial begin : drv
    logic [N-1:0] hs;
    int gcnt [N];
    snk_valid = '0; snk_sop = '0; snk_eop = '0;
    snk_data = '0; snk_empty = '0; snk_channel = '0;
    for (int i = 0; i < N; i++) gcnt[i] = 0;
    forever begin
      @(negedge clk);
      hs = snk_valid & snk_ready;
      @(posedge clk);
      #1;
      for (int i = 0; i < N; i++) begin
        if (hs[i] && txq[i].size() > 0) begin
          void'(txq[i].pop_front());
          gcnt[i] = 0;
        end
        if (txq[i].size() > 0 && gcnt[i] >= txq[i][0].gap) begin
          snk_valid[i]             = 1'b1;
          snk_data[i*DW +: DW]     = txq[i][0].d;
          snk_sop[i]               = txq[i][0].sop;
          snk_eop[i]               = txq[i][0].eop;
          snk_empty[i*EW +: EW]    = txq[i][0].emp;
          snk_channel[i*CW +: CW]  = txq[i][0].ch;
        end else begin
          if (txq[i].size() > 0) gcnt[i] = gcnt[i] + 1;
          else                   gcnt[i] = 0;
          snk_valid[i] = 1'b0;
        end
      end
    end
  end

  // Output monitor: scoreboard pop on handshake, hold check on stalled cycles.
  initial begin : mon
    exp_t        e;
    logic [72:0] cur;
    logic [72:0] held;
    logic        stall_prev;
    int          last_out;
    stall_prev = 1'b0;
    held       = '0;
    last_out   = 0;
    forever begin
      @(negedge clk);
      cur = {src_data, src_sop, src_eop, src_empty, src_channel};
      if (!arst_n) begin
        stall_prev = 1'b0;
      end else begin
        if (stall_prev) chk("stall_hold", 128'(cur), 128'(held));
        if (src_valid && src_ready) begin
          chk("beat_expected", 128'(sbq.size() != 0), 128'(1));
          if (sbq.size() != 0) begin
            e = sbq.pop_front();
            chk("beat", 128'(cur), 128'({e.d, e.sop, e.eop, e.emp, e.ch}));
            if (e.at >= 0)   chk("latency", 128'(cyc), 128'(e.at));
            if (e.dcyc >= 0) chk("spacing", 128'(cyc - last_out), 128'(e.dcyc));
            if (!stall_prev) begin
              chk("grant_idx", 128'(grant_idx), 128'(e.src));
              chk("busy", 128'(busy), 128'(!e.eop));
            end
          end
          last_out = cyc;
        end
        stall_prev = src_valid && !src_ready;
        held       = cur;
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic drain(input string tag, input int bound);
    int k;
    k = 0;
    while (sbq.size() != 0 && k < bound) begin
      @(negedge clk);
      k++;
    end
    chk(tag, 128'(sbq.size()), 128'(0));
    step(1);
  endtask

  task automatic do_reset();
    arst_n = 1'b0;
    for (int i = 0; i < N; i++) txq[i].delete();
    sbq.delete();
    src_ready = 1'b1;
    @(negedge clk);
    chk("rst_src_valid", 128'(src_valid), 128'(0));
    chk("rst_snk_ready", 128'(snk_ready), 128'(0));
    chk("rst_busy",      128'(busy),      128'(0));
    chk("rst_grant",     128'(grant_idx), 128'(0));
    chk("rst_src_flds",  128'({src_data, src_sop, src_eop, src_empty, src_channel}), 128'(0));
    step(1);
    arst_n = 1'b1;
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    int k;
    arst_n    = 1'b0;
    src_ready = 1'b0;

    // 1: single 3-beat packet on src0
    do_reset();
    send(0, 3, 3, 64'hD0, 4'd5, 3'd2, -1, 0, 1'b1, -1, 1);
    drain("t1_drain", 40);

    // 2: src0 and src1 start together; src0 first, one bubble, then src1
    do_reset();
    send(0, 2, 2, 64'hA0, 4'h1, 3'd3, -1, 0, 1'b1, -1, 1);
    send(1, 2, 2, 64'hB0, 4'h2, 3'd4, -1, 0, 1'b0,  2, 1);
    drain("t2_drain", 40);

    // 3: all sources stream single-beat packets; round-robin 0,1,2,3,0,1,2,3
    do_reset();
    for (int r = 0; r < 2; r++)
      for (int s = 0; s < N; s++)
        send(s, 1, 1, 64'h300 + 64'(16*r + s), 4'(s), 3'(s), -1, 0,
             (r == 0 && s == 0), (r == 0 && s == 0) ? -1 : 2, 1);
    drain("t3_drain", 80);

    // 4: src2 5-beat packet under toggling src_ready
    do_reset();
    send(2, 5, 5, 64'h400, 4'h7, 3'd5, -1, 0, 1'b0, -1, -1);
    for (int j = 0; j < 16; j++) begin
      src_ready = (j % 2 == 0);
      step(1);
    end
    src_ready = 1'b1;
    drain("t4_drain", 40);

    // 5: reset lands while beat 2 of a src3 packet is on the output
    do_reset();
    send(3, 4, 2, 64'h500, 4'h9, 3'd1, -1, 0, 1'b1, -1, 1);
    k = 0;
    while (sbq.size() != 0 && k < 40) begin
      @(negedge clk);
      k++;
    end
    chk("t5_two_beats_out", 128'(sbq.size()), 128'(0));
    step(1);
    arst_n = 1'b0;
    for (int i = 0; i < N; i++) txq[i].delete();
    #1;
    chk("t5_src_valid_clr", 128'(src_valid), 128'(0));
    chk("t5_snk_ready_clr", 128'(snk_ready), 128'(0));
    chk("t5_busy_clr",      128'(busy),      128'(0));
    step(2);
    send(0, 1, 1, 64'h5A0, 4'h3, 3'd2, -1, 0, 1'b1, -1, 1);
    send(3, 1, 1, 64'h5B0, 4'h4, 3'd6, -1, 0, 1'b0,  2, 1);
    arst_n = 1'b1;
    drain("t5_drain", 40);

    // 6: src1 holds its grant through a 3-cycle valid gap while src0 waits
    do_reset();
    send(1, 4, 4, 64'h600, 4'hA, 3'd6, 2, 3, 1'b1, -1, 1);
    step(2);
    send(0, 1, 1, 64'h6F0, 4'hB, 3'd7, -1, 0, 1'b0, 2, 1);
    k = 0;
    while (sbq.size() > 1 && k < 40) begin
      @(negedge clk);
      #1;
      chk("t6_rdy0_held", 128'(snk_ready[0]), 128'(0));
      k++;
    end
    chk("t6_bubble_rdy0", 128'(snk_ready[0]), 128'(0));
    drain("t6_drain", 40);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
